bp_me_io_cmd_arbiter: RTL and testbench
=======================================

Name: bp_me_io_cmd_arbiter

Overview:
- Shares one I/O memory-command link (host-side link bidir) among num_req_p loaders/requesters, e.g. CCE cfg loader, NBF loader, debug host.
- Round-robin grant on commands; in-order response return routed to the issuing requester via an ID FIFO.
- Credit-limits outstanding transactions.
- Replaces ad-hoc fixed mutex muxing in bench/top-level glue.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- msg_width_p, 128, width of packed bp_cce_mem_msg_s.
- max_outstanding_p, 4, max commands issued whose response is not yet yumi'd (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command; slot i at [i*msg_width_p+:msg_width_p]
- req_cmd_v_i  in  num_req_p  command valid
- req_cmd_ready_o  out  num_req_p  one-hot grant; transfer = v & ready
- req_resp_o  out  msg_width_p  response payload, broadcast to all requesters
- req_resp_v_o  out  num_req_p  one-hot response valid
- req_resp_yumi_i  in  num_req_p  response consume
- mem_cmd_o  out  msg_width_p  command to link
- mem_cmd_v_o  out  1  command valid
- mem_cmd_ready_i  in  1  link ready; transfer = v & ready
- mem_resp_i  in  msg_width_p  response from link
- mem_resp_v_i  in  1  response valid
- mem_resp_yumi_o  out  1  response consume
- idle_o  out  1  no outstanding transaction and output register empty

Behaviour:
- Reset (async assert, sync deassert):
  - cmd register empty; mem_cmd_v_o=0, mem_cmd_o=0.
  - ID FIFO empty; outstanding count=0.
  - rr pointer=num_req_p-1, so requester 0 has first priority.
  - req_cmd_ready_o=0, req_resp_v_o=0, mem_resp_yumi_o=0, idle_o=1.
- Command stage: one-entry output register {msg, src_id}.
  - free = ~reg_v | (mem_cmd_v_o & mem_cmd_ready_i).
  - can_grant = free & (count < max_outstanding_p).
  - Simultaneous retire does NOT free a credit in the same cycle; no comb path from resp to cmd.
- Arbitration, when can_grant:
  - Search from (rr+1) mod num_req_p upward with wrap.
  - First valid requester i gets req_cmd_ready_o[i]=1, only if req_cmd_v_i[i]; ready is never asserted to an invalid requester.
  - On grant: reg loads req_cmd_i slot i, reg_v=1, src i pushed into ID FIFO, count+1, rr=i.
  - No grant: rr unchanged.
- Latency: requester handshake at cycle N → mem_cmd_v_o=1 at N+1.
  - Back-to-back grants every cycle when the link is always ready and credits are available.
  - mem_cmd_o is held stable while mem_cmd_v_o & ~mem_cmd_ready_i.
- Response routing (responses arrive in order):
  - head = ID FIFO head; req_resp_o = mem_resp_i.
  - req_resp_v_o[head] = mem_resp_v_i & ~fifo_empty; all other bits 0.
  - mem_resp_yumi_o = req_resp_v_o[head] & req_resp_yumi_i[head].
  - On yumi: pop FIFO, count-1.
  - Yumi on a non-head bit is ignored.
- Count update: grant & retire in the same cycle → count unchanged; FIFO push and pop same cycle is legal at any occupancy < max.
- Boundaries:
  - count==max_outstanding_p → all ready=0.
  - mem_resp_v_i with FIFO empty → not consumed (yumi=0); simulation assertion fires (protocol error).
  - Pointer wraps modulo num_req_p.
- idle_o = ~reg_v & (count==0), registered-state derived (combinational from state only).
- Reset mid-transaction: all state cleared; in-flight responses are the link's responsibility (external reset is shared).

Optional Feature:
- Macro: BP_ME_IO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest valid index always wins; rr pointer not implemented; everything else identical.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: reset_n_i=0 with all inputs toggling → all outputs 0 except idle_o=1; release → req 0 and req 1 both valid, req 0 granted first.
- Round-robin: num_req_p=3, all valid continuously, link always ready, immediate responses → grant order 0,1,2,0,1,2; mem_cmd_v_o high every cycle after the first.
- Credit limit: link ready, responses withheld, req 0 valid → exactly 4 grants, then ready=0. One response yumi → count 3, grant resumes next cycle, not the same cycle.
- Routing: grants to 1,0,1 (payload tags A,B,C); responses R1,R2,R3 returned → req_resp_v_o = 0b10, 0b01, 0b10 in order. Requester 0 delays yumi 5 cycles → mem_resp_yumi_o stays 0 for those cycles.
- Backpressure: mem_cmd_ready_i=0 for 10 cycles with reg full → mem_cmd_o stable, all ready=0. Ready=1 together with a pending request → transfer and new grant in the same cycle.
- Fixed-prio build with BP_ME_IO_ARB_FIXED_PRIO_EN, all valid → requester 0 granted every cycle; response with empty FIFO → yumi=0 and assertion reported.

Source files
------------

// File: rtl/bp_me_io_cmd_arbiter.sv
// Shares one I/O memory-command link among num_req_p requesters: round-robin command grant,
// in-order response routing via an ID FIFO, credit-limited. BP_ME_IO_ARB_FIXED_PRIO_EN selects fixed priority.
module bp_me_io_cmd_arbiter #(
   parameter int num_req_p         = 2,
   parameter int msg_width_p       = 128,
   parameter int max_outstanding_p = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
   input  logic [num_req_p-1:0]             req_cmd_v_i,
   output logic [num_req_p-1:0]             req_cmd_ready_o,
   output logic [msg_width_p-1:0]           req_resp_o,
   output logic [num_req_p-1:0]             req_resp_v_o,
   input  logic [num_req_p-1:0]             req_resp_yumi_i,
   output logic [msg_width_p-1:0]           mem_cmd_o,
   output logic                             mem_cmd_v_o,
   input  logic                             mem_cmd_ready_i,
   input  logic [msg_width_p-1:0]           mem_resp_i,
   input  logic                             mem_resp_v_i,
   output logic                             mem_resp_yumi_o,
   output logic                             idle_o
);

   localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int ptr_w = $clog2(max_outstanding_p);
   localparam int cnt_w = $clog2(max_outstanding_p + 1);

   logic [msg_width_p-1:0] msg_q, msg_d;
   logic                   reg_v_q, reg_v_d;
   logic [id_w-1:0]        id_fifo_q [max_outstanding_p];
   logic [id_w-1:0]        id_fifo_d [max_outstanding_p];
   logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [cnt_w-1:0]       cnt_q, cnt_d;
`ifndef BP_ME_IO_ARB_FIXED_PRIO_EN
   logic [id_w-1:0]        rr_q, rr_d;
`endif

   logic [msg_width_p-1:0] slot [num_req_p];
   logic                   free, can_grant, gnt_found, grant, retire, fifo_empty;
   logic [id_w-1:0]        gnt_idx, head;

   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         slot[i] = req_cmd_i[i*msg_width_p +: msg_width_p];
      end
   end

   assign fifo_empty = (cnt_q == '0);
   assign free       = ~reg_v_q | (reg_v_q & mem_cmd_ready_i);
   // Credits come from the registered count only, so a retire never feeds the grant path.
   assign can_grant  = reset_n_i & free & (cnt_q < cnt_w'(max_outstanding_p));

   always_comb begin
      int cand;
      cand      = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int j = 0; j < num_req_p; j++) begin
`ifdef BP_ME_IO_ARB_FIXED_PRIO_EN
         cand = j;
`else
         cand = (int'(rr_q) + 1 + j) % num_req_p;
`endif
         if (!gnt_found && req_cmd_v_i[id_w'(cand)]) begin
            gnt_found = 1'b1;
            gnt_idx   = id_w'(cand);
         end
      end
   end

   assign grant = can_grant & gnt_found;

   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         req_cmd_ready_o[i] = grant & (gnt_idx == id_w'(i));
      end
   end

   assign head = id_fifo_q[rd_ptr_q];

   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         req_resp_v_o[i] = mem_resp_v_i & ~fifo_empty & (head == id_w'(i));
      end
   end

   // Only the head bit of req_resp_v_o can be set, so a yumi on any other bit is masked off.
   assign mem_resp_yumi_o = |(req_resp_v_o & req_resp_yumi_i);
   assign retire          = mem_resp_yumi_o;
   assign req_resp_o      = mem_resp_i;
   assign mem_cmd_o       = msg_q;
   assign mem_cmd_v_o     = reg_v_q;
   assign idle_o          = ~reg_v_q & fifo_empty;

   always_comb begin
      msg_d     = msg_q;
      reg_v_d   = reg_v_q;
      id_fifo_d = id_fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
`ifndef BP_ME_IO_ARB_FIXED_PRIO_EN
      rr_d      = rr_q;
`endif
      if (grant) begin
         msg_d               = slot[gnt_idx];
         reg_v_d             = 1'b1;
         id_fifo_d[wr_ptr_q] = gnt_idx;
         wr_ptr_d            = wr_ptr_q + 1'b1;
`ifndef BP_ME_IO_ARB_FIXED_PRIO_EN
         rr_d                = gnt_idx;
`endif
      end else if (reg_v_q & mem_cmd_ready_i) begin
         reg_v_d = 1'b0;
      end
      if (retire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({grant, retire})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         msg_q    <= '0;
         reg_v_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < max_outstanding_p; i++) begin
            id_fifo_q[i] <= '0;
         end
`ifndef BP_ME_IO_ARB_FIXED_PRIO_EN
         rr_q     <= id_w'(num_req_p - 1);
`endif
      end else begin
         msg_q     <= msg_d;
         reg_v_q   <= reg_v_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         id_fifo_q <= id_fifo_d;
`ifndef BP_ME_IO_ARB_FIXED_PRIO_EN
         rr_q      <= rr_d;
`endif
      end
   end

`ifndef SYNTHESIS
   // A response with nothing outstanding means the link broke protocol.
   resp_without_cmd_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(mem_resp_v_i && fifo_empty));
`endif

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Randomized bench for bp_me_io_cmd_arbiter: a transaction-level model predicts grants,
// and a monitor scores link commands and routed responses against queued expectations.
module tb_bp_me_io_cmd_arbiter;
   localparam int N   = 3;
   localparam int W   = 32;
   localparam int MAX = 4;
   localparam logic [W-1:0] RESP_KEY = 32'h5A5A_5A5A;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N*W-1:0]   req_cmd;
   logic [N-1:0]     req_cmd_v;
   logic [N-1:0]     req_cmd_ready;
   logic [W-1:0]     req_resp;
   logic [N-1:0]     req_resp_v;
   logic [N-1:0]     req_resp_yumi;
   logic [W-1:0]     mem_cmd;
   logic             mem_cmd_v;
   logic             mem_cmd_ready;
   logic [W-1:0]     mem_resp;
   logic             mem_resp_v;
   logic             mem_resp_yumi;
   logic             idle;

   always #5 clk = ~clk;

   bp_me_io_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(MAX)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .req_cmd_i(req_cmd), .req_cmd_v_i(req_cmd_v), .req_cmd_ready_o(req_cmd_ready),
      .req_resp_o(req_resp), .req_resp_v_o(req_resp_v), .req_resp_yumi_i(req_resp_yumi),
      .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
      .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi),
      .idle_o(idle)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic bitof(input logic [N-1:0] vec, input int idx);
      logic [N-1:0] t;
      t = vec >> idx;
      return t[0];
   endfunction

   function automatic logic [W-1:0] payload(input int req, input int seq);
      return {req[7:0], 8'hA5, seq[15:0]};
   endfunction

   // scoreboard queues: filled by the model, drained by the monitor
   logic [W-1:0] cmd_exp [$];
   int           route_exp [$];
   // reference model state
   int           m_ids [$];
   int           m_last;
   bit           m_reg_v;
   int           seq [N];
   int           pg;
   bit           p_accept, p_yumi;
   // link model
   logic [W-1:0] link_q [$];
   // knobs
   int           p_v, p_rdy, p_rv, p_y;
   bit           use_force;
   logic [N-1:0] force_mask;
   bit           mon_en = 1'b0;

   task automatic drive_inputs();
      logic [N-1:0] v, y;
      v = '0;
      y = '0;
      for (int i = 0; i < N; i++) begin
         if (use_force ? bitof(force_mask, i) : ($urandom % 100 < p_v)) v |= N'(1) << i;
         if ($urandom % 100 < p_y) y |= N'(1) << i;
         req_cmd[i*W +: W] = payload(i, seq[i]);
      end
      req_cmd_v     = v;
      req_resp_yumi = y;
      mem_cmd_ready = ($urandom % 100 < p_rdy);
      mem_resp_v    = (link_q.size() > 0) && ($urandom % 100 < p_rv);
      mem_resp      = mem_resp_v ? link_q[0] : W'($urandom);
   endtask

   task automatic cycle();
      int c;
      logic [N-1:0] exp_rdy;
      @(posedge clk);
      if (pg >= 0) begin
         m_ids.push_back(pg);
         route_exp.push_back(pg);
         cmd_exp.push_back(payload(pg, seq[pg]));
         seq[pg]++;
         m_last  = pg;
         m_reg_v = 1'b1;
      end else if (p_accept) begin
         m_reg_v = 1'b0;
      end
      if (p_yumi) void'(m_ids.pop_front());
      #1;
      drive_inputs();
      @(negedge clk);
      pg = -1;
      if ((!m_reg_v || mem_cmd_ready) && m_ids.size() < MAX) begin
         for (int k = 1; k <= N; k++) begin
`ifdef BP_ME_IO_ARB_FIXED_PRIO_EN
            c = k - 1;
`else
            c = (m_last + k) % N;
`endif
            if (pg < 0 && bitof(req_cmd_v, c)) pg = c;
         end
      end
      exp_rdy  = (pg >= 0) ? (N'(1) << pg) : '0;
      p_accept = m_reg_v && mem_cmd_ready;
      p_yumi   = mem_resp_v && (m_ids.size() > 0) && bitof(req_resp_yumi, m_ids[0]);
      chk("req_cmd_ready", 64'(req_cmd_ready), 64'(exp_rdy));
      chk("mem_cmd_v", 64'(mem_cmd_v), 64'(m_reg_v));
      chk("idle", 64'(idle), 64'(!m_reg_v && m_ids.size() == 0));
      if (mem_resp_yumi && link_q.size() > 0) void'(link_q.pop_front());
      if (mem_cmd_v && mem_cmd_ready) link_q.push_back(mem_cmd ^ RESP_KEY);
   endtask

   task automatic phase(input int n, input int v, input int rdy, input int rv, input int y,
                        input bit frc, input logic [N-1:0] mask);
      p_v = v; p_rdy = rdy; p_rv = rv; p_y = y; use_force = frc; force_mask = mask;
      for (int i = 0; i < n; i++) cycle();
   endtask

   // monitor: scores link-side command transfers and requester-side responses
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_cmd;
   int           mon_route;
   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         if (mem_cmd_v && mem_cmd_ready) begin
            if (cmd_exp.size() == 0) chk("mem_cmd_unexpected", 64'(mem_cmd), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("mem_cmd_payload", 64'(mem_cmd), 64'(cmd_exp.pop_front()));
         end
         if (prev_stall) chk("mem_cmd_hold", 64'(mem_cmd), 64'(prev_cmd));
         prev_stall = mem_cmd_v && !mem_cmd_ready;
         prev_cmd   = mem_cmd;
         if (mem_resp_v) begin
            if (route_exp.size() == 0) begin
               chk("resp_no_outstanding", 64'(req_resp_v), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               mon_route = route_exp[0];
               chk("req_resp_v", 64'(req_resp_v), 64'(N'(1) << mon_route));
               chk("req_resp_payload", 64'(req_resp), 64'(mem_resp));
               chk("mem_resp_yumi", 64'(mem_resp_yumi), 64'(bitof(req_resp_yumi, mon_route)));
               if (bitof(req_resp_yumi, mon_route)) void'(route_exp.pop_front());
            end
         end else begin
            chk("req_resp_v_idle", 64'(req_resp_v), 64'd0);
            chk("mem_resp_yumi_idle", 64'(mem_resp_yumi), 64'd0);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) seq[i] = 0;
      m_last = N - 1; m_reg_v = 1'b0; pg = -1; p_accept = 1'b0; p_yumi = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         req_cmd       = {N{W'($urandom)}};
         req_cmd_v     = N'($urandom);
         req_resp_yumi = N'($urandom);
         mem_cmd_ready = 1'($urandom);
         mem_resp      = W'($urandom);
         mem_resp_v    = 1'($urandom);
         @(negedge clk);
         chk("rst_ready", 64'(req_cmd_ready), 64'd0);
         chk("rst_resp_v", 64'(req_resp_v), 64'd0);
         chk("rst_mem_cmd_v", 64'(mem_cmd_v), 64'd0);
         chk("rst_mem_cmd", 64'(mem_cmd), 64'd0);
         chk("rst_yumi", 64'(mem_resp_yumi), 64'd0);
         chk("rst_idle", 64'(idle), 64'd1);
      end
      @(posedge clk); #1;
      req_cmd_v = '0; req_resp_yumi = '0; mem_cmd_ready = 1'b0; mem_resp_v = 1'b0;
      #2 reset_n = 1'b1;
      mon_en = 1'b1;
      // req 0 and 1 both valid after reset: req 0 must win
      phase(1, 0, 100, 0, 0, 1'b1, 3'b011);
      // all valid, link ready, immediate responses
      phase(30, 0, 100, 100, 100, 1'b1, 3'b111);
      // credits: only req 0, responses withheld, then released
      phase(12, 0, 100, 0, 0, 1'b1, 3'b001);
      phase(6, 0, 100, 100, 100, 1'b1, 3'b001);
      // link backpressure with pending requests, then release
      phase(10, 70, 0, 50, 50, 1'b0, '0);
      phase(10, 70, 100, 50, 50, 1'b0, '0);
      // random mixes
      for (int r = 0; r < 8; r++) begin
         phase(200, $urandom_range(10, 100), $urandom_range(10, 100),
               $urandom_range(0, 100), $urandom_range(10, 100), 1'b0, '0);
      end
      // drain everything outstanding
      phase(60, 0, 100, 100, 100, 1'b1, 3'b000);
      chk("drain_cmd_exp", 64'(cmd_exp.size()), 64'd0);
      chk("drain_route_exp", 64'(route_exp.size()), 64'd0);
      chk("drain_idle", 64'(idle), 64'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
